mem_port_arbiter: RTL

//  Shares one single-ported instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the shared-memory port arbiter, the pipeline
// stages and the single-ported memory.
//   Fetch side : if_req, if_addr -> if_rdata, if_done, stall_if
//   Data side  : dm_read, dm_write, dm_addr, dm_wdata, dm_be -> dm_rdata, dm_done, stall_mem
//   Memory side: mem_en, mem_we, mem_addr, mem_wdata, mem_be -> mem_rdata
// The arbiter owns the bus and uses modport master. The pipeline and the
// memory together form the other side and use modport slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [3:0]        dm_be;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_rdata, if_done, dm_rdata, dm_done,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall_if, stall_mem
  );

  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_rdata, if_done, dm_rdata, dm_done,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported instruction/data memory between the fetch stage
// and the load/store stage. Only one transaction is in flight at a time.
// Each transaction takes MEM_LAT cycles after the grant cycle. When both
// stages request at once, the stage that was not served last time wins.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.master (fetch, data and memory sides)
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus
);

  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_dm_r;   // 1: the previous grant went to the data side
  logic              store_r;     // the transaction in flight is a store
  logic              dm_req_s;
  logic              grant_if_s;
  logic              grant_dm_s;
  logic              complete_s;
  logic              if_done_s;
  logic              dm_done_s;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [3:0]        mem_be_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] dm_rdata_r;

  assign dm_req_s = bus.dm_read | bus.dm_write;

  // Arbitration in IDLE and completion detection while busy
  always_comb begin
    state_nxt_s = state_r;
    grant_if_s  = 1'b0;
    grant_dm_s  = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.if_req && dm_req_s) begin
          // Contention: alternate so neither stage can starve the other.
          if (last_dm_r) begin
            grant_if_s = 1'b1;
          end else begin
            grant_dm_s = 1'b1;
          end
        end else if (bus.if_req) begin
          grant_if_s = 1'b1;
        end else if (dm_req_s) begin
          grant_dm_s = 1'b1;
        end else begin
          grant_dm_s = 1'b0;
        end
        if (grant_dm_s) begin
          state_nxt_s = ST_BUSY_DM;
        end else if (grant_if_s) begin
          state_nxt_s = ST_BUSY_IF;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        if (cnt_r == CNT_ZERO) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // A withdrawn request still finishes on the memory side, but its done pulse is suppressed.
  assign if_done_s = complete_s & (state_r == ST_BUSY_IF) & bus.if_req;
  assign dm_done_s = complete_s & (state_r == ST_BUSY_DM) & dm_req_s;

  // State, latency counter and grant history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      last_dm_r <= 1'b0;
      store_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_if_s || grant_dm_s) begin
        cnt_r     <= CNT_LOAD;
        last_dm_r <= grant_dm_s;
        store_r   <= grant_dm_s & bus.dm_write;
      end else if (cnt_r != CNT_ZERO) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Memory request registers: the strobe lasts one cycle and the address fields hold until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_be_r    <= 4'h0;
    end else begin
      mem_en_r <= grant_if_s | grant_dm_s;
      mem_we_r <= grant_dm_s & bus.dm_write;
      if (grant_dm_s) begin
        mem_addr_r  <= bus.dm_addr;
        mem_wdata_r <= bus.dm_wdata;
        // A combined read+write request counts as a store.
        mem_be_r    <= bus.dm_write ? bus.dm_be : 4'hF;
      end else if (grant_if_s) begin
        mem_addr_r <= bus.if_addr;
        mem_be_r   <= 4'hF;
      end
    end
  end

  // Read-data capture on delivered completions only; a store leaves dm_rdata untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_r <= {DATA_W{1'b0}};
      dm_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (if_done_s) begin
        if_rdata_r <= bus.mem_rdata;
      end
      if (dm_done_s && !store_r) begin
        dm_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_done   = if_done_s;
  assign bus.dm_done   = dm_done_s;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.dm_rdata  = dm_rdata_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.stall_if  = bus.if_req & ~if_done_s;
  assign bus.stall_mem = dm_req_s & ~dm_done_s;

endmodule
